// File: rtl/bitcnt_pkg.sv
// rtl/bitcnt_pkg.sv - shared op encoding and result-width helper for the bit-count unit (BITCNT_CPOP_EN)
package bitcnt_pkg;

  typedef enum logic [1:0] {
    BITCNT_CLZ  = 2'b00,
    BITCNT_CTZ  = 2'b01,
    BITCNT_CPOP = 2'b10,
    BITCNT_RSVD = 2'b11
  } bitcnt_op_e;

  // Result width: one extra bit so a zero operand can report XLEN.
  function automatic int bitcnt_cw(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/bitcnt_chunk.sv
// rtl/bitcnt_chunk.sv - per-chunk zero flag, leading-zero count and popcount (popcount only with BITCNT_CPOP_EN)
module bitcnt_chunk #(
  parameter int CHUNK = 8,
  parameter int LW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] i_bits,
`ifdef BITCNT_CPOP_EN
  input  logic             i_pop,
`endif
  output logic             o_zero,
  output logic [LW-1:0]    o_count
);

  logic [LW-1:0] w_lz;

  assign o_zero = ~|i_bits;

  // Leading-zero count: scanning upward, the highest set bit writes last.
  always_comb begin
    w_lz = LW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (i_bits[i]) w_lz = LW'(CHUNK - 1 - i);
    end
  end

`ifdef BITCNT_CPOP_EN
  logic [LW-1:0] w_pop;

  // Population count of the chunk.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + LW'(i_bits[i]);
    end
  end

  assign o_count = i_pop ? w_pop : w_lz;
`else
  assign o_count = w_lz;
`endif

endmodule

// File: rtl/bit_count_unit.sv
// rtl/bit_count_unit.sv - two-stage valid/ready CLZ/CTZ/CPOP unit (CPOP logic present only with BITCNT_CPOP_EN)
module bit_count_unit
  import bitcnt_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_src,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [bitcnt_cw(XLEN)-1:0] out_count,
  output logic                      out_zero
);

  localparam int NCH = XLEN / CHUNK;
  localparam int CW  = bitcnt_cw(XLEN);
  localparam int LW  = $clog2(CHUNK) + 1;

  logic            w_is_ctz;
  logic [XLEN-1:0] w_rev;
  logic [XLEN-1:0] w_src;
  logic            w_zero;
  logic [NCH-1:0]  w_czero;
  logic [LW-1:0]   w_ccnt [NCH];
  logic            w_s1_adv;
  logic [CW-1:0]   w_lead;
  logic [CW-1:0]   w_count;

  logic            r_s1_valid;
  logic            r_s1_zero;
  logic [NCH-1:0]  r_s1_czero;
  logic [LW-1:0]   r_s1_cnt [NCH];
  logic            r_out_valid;
  logic [CW-1:0]   r_out_count;
  logic            r_out_zero;

  // CTZ is CLZ of the bit-reversed operand; reserved op falls through to CLZ.
  assign w_is_ctz = (in_op == BITCNT_CTZ);
  assign w_zero   = ~|in_src;

  // Bit-reverse of the operand for CTZ.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_rev[i] = in_src[XLEN-1-i];
    end
  end

  assign w_src = w_is_ctz ? w_rev : in_src;

`ifdef BITCNT_CPOP_EN
  logic w_is_pop;
  logic r_s1_pop;
  assign w_is_pop = (in_op == BITCNT_CPOP);
`endif

  for (genvar j = 0; j < NCH; j++) begin : g_chunk
    bitcnt_chunk #(.CHUNK(CHUNK), .LW(LW)) u_chunk (
      .i_bits  (w_src[j*CHUNK +: CHUNK]),
`ifdef BITCNT_CPOP_EN
      .i_pop   (w_is_pop),
`endif
      .o_zero  (w_czero[j]),
      .o_count (w_ccnt[j])
    );
  end

  // S1 moves on whenever OUT is empty or being drained; no skid buffer.
  assign w_s1_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s1_adv;

  // Stage-1 register: per-chunk flags and counts plus operand-zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_zero  <= w_zero;
        r_s1_czero <= w_czero;
        r_s1_cnt   <= w_ccnt;
`ifdef BITCNT_CPOP_EN
        r_s1_pop   <= w_is_pop;
`endif
      end
    end
  end

  // Leading count from the most significant non-zero chunk; XLEN if none.
  always_comb begin
    w_lead = CW'(XLEN);
    for (int j = 0; j < NCH; j++) begin
      if (!r_s1_czero[j]) w_lead = CW'((NCH - 1 - j) * CHUNK) + CW'(r_s1_cnt[j]);
    end
  end

`ifdef BITCNT_CPOP_EN
  logic [CW-1:0] w_sum;

  // Sum of the chunk popcounts.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < NCH; j++) begin
      w_sum = w_sum + CW'(r_s1_cnt[j]);
    end
  end

  assign w_count = r_s1_pop ? w_sum : w_lead;
`else
  assign w_count = w_lead;
`endif

  // Output register: result held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_count <= w_count;
        r_out_zero  <= r_s1_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_zero  = r_out_zero;

endmodule
